vend_controller: RTL and testbench

Vending-machine sequencer fed by the coin input synchronizer. It accepts the one-cycle coin pulses (nickel, dime, quarter, dollar) and accumulates credit in cents. It handles buy and cancel requests, fires a one-cycle vend strobe, and pays out change or a refund as spaced coin-dispense pulses, largest denomination first.

---
 rtl/vend_controller.sv | 201 ++++++++++++++++++++
 tb/tb_vend_controller.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/vend_controller.sv
`default_nettype none
// ============================================================================
// Module   : vend_controller
// Purpose  : Vending-machine sequencer. Accumulates credit from synchronized
//            one-cycle coin pulses, services buy/cancel requests, strobes the
//            item release and pays change/refund as spaced coin pulses,
//            largest denomination first.
// Ports    : clk, rst_n            - clock, asynchronous active-low reset
//            n_s_i/di_s_i/q_s_i/dol_s_i - coin pulses (5/10/25/100 cents)
//            buy_i, cancel_i       - request levels, sampled every cycle
//            credit_o              - current credit in cents
//            vend_o                - one-cycle item-release strobe
//            deny_o                - one-cycle pulse, buy with too little credit
//            coin_reject_o         - one-cycle pulse, a coin was not credited
//            chg_q_o/chg_di_o/chg_n_o - one-cycle change-coin pulses
//            busy_o                - high whenever the sequencer is not idle
// Revision : 1.0 - initial release
// ============================================================================
module vend_controller #(
    parameter int PRICE      = 75,
    parameter int CREDIT_MAX = 200,
    parameter int CHG_GAP    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       n_s_i,
    input  logic       di_s_i,
    input  logic       q_s_i,
    input  logic       dol_s_i,
    input  logic       buy_i,
    input  logic       cancel_i,
    output logic [7:0] credit_o,
    output logic       vend_o,
    output logic       deny_o,
    output logic       coin_reject_o,
    output logic       chg_q_o,
    output logic       chg_di_o,
    output logic       chg_n_o,
    output logic       busy_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_VEND   = 2'd1,
        S_CHANGE = 2'd2,
        S_GAP    = 2'd3
    } state_t;

    // GAP lasts CHG_GAP-1 cycles; the counter is loaded with CHG_GAP-2 and
    // the state exits when it reaches zero.
    localparam int             GAP_W      = (CHG_GAP > 2) ? $clog2(CHG_GAP) : 1;
    localparam logic [GAP_W-1:0] C_GAP_LOAD = GAP_W'(CHG_GAP - 2);
    localparam logic [7:0]     C_PRICE    = 8'(PRICE);
    localparam logic [8:0]     C_MAX9     = 9'(CREDIT_MAX);

    state_t           state_q, state_d;
    logic [7:0]       credit_q, credit_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             deny_q, deny_d;
    logic             reject_q, reject_d;

    logic [7:0]       coin_val;
    logic             coin_any;
    logic             coin_lower;   // a lower-priority coin beside the chosen one
    logic [8:0]       coin_sum;     // 9 bits so the ceiling check cannot wrap

    // ------------------------------------------------------------------
    // Coin priority decode: only the highest-value asserted coin counts.
    // ------------------------------------------------------------------
    always_comb begin
        coin_val   = 8'd0;
        coin_lower = 1'b0;
        if (dol_s_i) begin
            coin_val   = 8'd100;
            coin_lower = q_s_i | di_s_i | n_s_i;
        end else if (q_s_i) begin
            coin_val   = 8'd25;
            coin_lower = di_s_i | n_s_i;
        end else if (di_s_i) begin
            coin_val   = 8'd10;
            coin_lower = n_s_i;
        end else if (n_s_i) begin
            coin_val   = 8'd5;
        end
        coin_any = dol_s_i | q_s_i | di_s_i | n_s_i;
        coin_sum = {1'b0, credit_q} + {1'b0, coin_val};
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        gap_d    = gap_q;
        deny_d   = 1'b0;
        reject_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cancel_i && (credit_q != 8'd0)) begin
                    state_d  = S_CHANGE;
                    reject_d = coin_any;
                end else if (buy_i && (credit_q >= C_PRICE)) begin
                    state_d  = S_VEND;
                    credit_d = credit_q - C_PRICE;
                    reject_d = coin_any;
                end else begin
                    // A denied buy (or an ignored zero-credit cancel) does
                    // not block coin acceptance in the same cycle.
                    deny_d = buy_i;
                    if (coin_any) begin
                        if (coin_sum <= C_MAX9) begin
                            credit_d = coin_sum[7:0];
                            reject_d = coin_lower;
                        end else begin
                            reject_d = 1'b1;
                        end
                    end
                end
            end

            S_VEND: begin
                reject_d = coin_any;
                state_d  = (credit_q != 8'd0) ? S_CHANGE : S_IDLE;
            end

            S_CHANGE: begin
                reject_d = coin_any;
                gap_d    = C_GAP_LOAD;
                state_d  = S_GAP;
                if (credit_q >= 8'd25) begin
                    credit_d = credit_q - 8'd25;
                end else if (credit_q >= 8'd10) begin
                    credit_d = credit_q - 8'd10;
                end else if (credit_q >= 8'd5) begin
                    credit_d = credit_q - 8'd5;
                end
            end

            S_GAP: begin
                reject_d = coin_any;
                if (gap_q == '0) begin
                    state_d = (credit_q != 8'd0) ? S_CHANGE : S_IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            credit_q <= 8'd0;
            gap_q    <= '0;
            deny_q   <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            gap_q    <= gap_d;
            deny_q   <= deny_d;
            reject_q <= reject_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Strobes decode the registered state, so the async reset
    // clears them immediately. The dispensed coin is chosen from the credit
    // still owed at the start of the CHANGE cycle.
    // ------------------------------------------------------------------
    always_comb begin
        credit_o      = credit_q;
        deny_o        = deny_q;
        coin_reject_o = reject_q;
        vend_o        = (state_q == S_VEND);
        busy_o        = (state_q != S_IDLE);
        chg_q_o       = 1'b0;
        chg_di_o      = 1'b0;
        chg_n_o       = 1'b0;
        if (state_q == S_CHANGE) begin
            if (credit_q >= 8'd25) begin
                chg_q_o = 1'b1;
            end else if (credit_q >= 8'd10) begin
                chg_di_o = 1'b1;
            end else if (credit_q >= 8'd5) begin
                chg_n_o = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vend_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_vend_controller
// Purpose  : Directed self-checking bench for vend_controller (PRICE=75,
//            CREDIT_MAX=200, CHG_GAP=2). Inputs change on falling edges;
//            outputs are observed on falling edges.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vend_controller;

    logic       clk;
    logic       rst_n;
    logic       n_s, di_s, q_s, dol_s, buy, cancel;
    logic [7:0] credit;
    logic       vend, deny, coin_reject, chg_q, chg_di, chg_n, busy;

    int total = 0;
    int bad   = 0;

    // flag order for checks: vend, deny, reject, chg_q, chg_di, chg_n, busy
    localparam logic [6:0] F_NONE = 7'b000_0000;
    localparam logic [6:0] F_VEND = 7'b100_0000;
    localparam logic [6:0] F_DENY = 7'b010_0000;
    localparam logic [6:0] F_REJ  = 7'b001_0000;
    localparam logic [6:0] F_CQ   = 7'b000_1000;
    localparam logic [6:0] F_CD   = 7'b000_0100;
    localparam logic [6:0] F_CN   = 7'b000_0010;
    localparam logic [6:0] F_BUSY = 7'b000_0001;

    vend_controller #(
        .PRICE      (75),
        .CREDIT_MAX (200),
        .CHG_GAP    (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .n_s_i         (n_s),
        .di_s_i        (di_s),
        .q_s_i         (q_s),
        .dol_s_i       (dol_s),
        .buy_i         (buy),
        .cancel_i      (cancel),
        .credit_o      (credit),
        .vend_o        (vend),
        .deny_o        (deny),
        .coin_reject_o (coin_reject),
        .chg_q_o       (chg_q),
        .chg_di_o      (chg_di),
        .chg_n_o       (chg_n),
        .busy_o        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wait for a falling edge, then drive the given inputs for one cycle.
    task automatic apply(input logic n, input logic di, input logic q,
                         input logic dol, input logic b, input logic c);
        @(negedge clk);
        n_s = n; di_s = di; q_s = q; dol_s = dol; buy = b; cancel = c;
    endtask

    task automatic idle();
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk(input string tag, input logic [7:0] exp_credit,
                       input logic [6:0] exp_flags);
        logic [14:0] obs;
        logic [14:0] exp;
        obs = {credit, vend, deny, coin_reject, chg_q, chg_di, chg_n, busy};
        exp = {exp_credit, exp_flags};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed credit=%0d flags=%b expected credit=%0d flags=%b",
                   tag, obs[14:7], obs[6:0], exp[14:7], exp[6:0]);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        n_s = 0; di_s = 0; q_s = 0; dol_s = 0; buy = 0; cancel = 0;
        repeat (2) @(negedge clk);
        chk("reset", 8'd0, F_NONE);
        rst_n = 1'b1;

        // Zero-credit cancel is ignored; the buy beside it is then denied.
        apply(0, 0, 0, 0, 1, 1); idle(); chk("cancel0_buy_deny", 8'd0, F_DENY);
        idle();                          chk("cancel0_after",    8'd0, F_NONE);

        // Exact payment: three quarters then buy, no change.
        apply(0, 0, 1, 0, 0, 0); idle(); chk("q1", 8'd25, F_NONE);
        apply(0, 0, 1, 0, 0, 0); idle(); chk("q2", 8'd50, F_NONE);
        apply(0, 0, 1, 0, 0, 0); idle(); chk("q3", 8'd75, F_NONE);
        apply(0, 0, 0, 0, 1, 0); idle(); chk("exact_vend", 8'd0, F_VEND | F_BUSY);
        idle();                          chk("exact_idle", 8'd0, F_NONE);

        // Dollar then buy: one quarter of change.
        apply(0, 0, 0, 1, 0, 0); idle(); chk("dol", 8'd100, F_NONE);
        apply(0, 0, 0, 0, 1, 0); idle(); chk("dol_vend", 8'd25, F_VEND | F_BUSY);
        idle();                          chk("dol_chg", 8'd25, F_CQ | F_BUSY);
        idle();                          chk("dol_gap", 8'd0, F_BUSY);
        idle();                          chk("dol_idle", 8'd0, F_NONE);

        // Ceiling: 200 then a nickel is rejected; buy leaves 125 = 5 quarters.
        apply(0, 0, 0, 1, 0, 0); idle(); chk("max_d1", 8'd100, F_NONE);
        apply(0, 0, 0, 1, 0, 0); idle(); chk("max_d2", 8'd200, F_NONE);
        apply(1, 0, 0, 0, 0, 0); idle(); chk("max_rej", 8'd200, F_REJ);
        apply(0, 0, 0, 0, 1, 0); idle(); chk("max_vend", 8'd125, F_VEND | F_BUSY);
        for (int i = 0; i < 5; i++) begin
            idle(); chk($sformatf("max_chg%0d", i), 8'(125 - 25 * i), F_CQ | F_BUSY);
            idle(); chk($sformatf("max_gap%0d", i), 8'(100 - 25 * i), F_BUSY);
        end
        idle();                          chk("max_idle", 8'd0, F_NONE);

        // Two coins together: quarter credited, nickel rejected.
        apply(1, 0, 1, 0, 0, 0); idle(); chk("qn_same", 8'd25, F_REJ);
        apply(0, 0, 0, 0, 0, 1); idle(); chk("qn_ref_chg", 8'd25, F_CQ | F_BUSY);
        idle();                          chk("qn_ref_gap", 8'd0, F_BUSY);
        idle();                          chk("qn_ref_idle", 8'd0, F_NONE);

        // Refund of 40: quarter, dime, nickel; a nickel during GAP is rejected.
        apply(0, 0, 1, 0, 0, 0); idle(); chk("r40_q", 8'd25, F_NONE);
        apply(0, 1, 0, 0, 0, 0); idle(); chk("r40_d", 8'd35, F_NONE);
        apply(1, 0, 0, 0, 0, 0); idle(); chk("r40_n", 8'd40, F_NONE);
        apply(0, 0, 0, 0, 0, 1); idle(); chk("r40_chg_q", 8'd40, F_CQ | F_BUSY);
        apply(1, 0, 0, 0, 0, 0);         chk("r40_gap1", 8'd15, F_BUSY);
        idle();                          chk("r40_chg_d", 8'd15, F_CD | F_REJ | F_BUSY);
        idle();                          chk("r40_gap2", 8'd5, F_BUSY);
        idle();                          chk("r40_chg_n", 8'd5, F_CN | F_BUSY);
        idle();                          chk("r40_gap3", 8'd0, F_BUSY);
        idle();                          chk("r40_idle", 8'd0, F_NONE);

        // Insufficient credit: deny, credit unchanged.
        apply(0, 1, 0, 0, 0, 0); idle(); chk("deny_d", 8'd10, F_NONE);
        apply(0, 0, 0, 0, 1, 0); idle(); chk("deny", 8'd10, F_DENY);
        idle();                          chk("deny_after", 8'd10, F_NONE);

        // Reset during the GAP of a refund (credit 35 -> 10 owed).
        apply(0, 0, 1, 0, 0, 0); idle(); chk("rst_q", 8'd35, F_NONE);
        apply(0, 0, 0, 0, 0, 1); idle(); chk("rst_chg", 8'd35, F_CQ | F_BUSY);
        idle();                          chk("rst_gap", 8'd10, F_BUSY);
        rst_n = 1'b0;
        #1;
        chk("rst_async", 8'd0, F_NONE);
        @(negedge clk);
        chk("rst_held", 8'd0, F_NONE);
        rst_n = 1'b1;
        apply(0, 1, 0, 0, 0, 0); idle(); chk("post_rst_coin", 8'd10, F_NONE);
        idle();                          chk("post_rst_idle", 8'd10, F_NONE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
